// File: rtl/vga_framebuffer_scanout.sv
// 160x120x3 framebuffer with a pixel-plot write port and continuous 640x480@60 VGA scan-out,
// each stored pixel shown as a 4x4 block. The framebuffer is cleared after every reset.
module vga_framebuffer_scanout #(
    parameter int unsigned H_VISIBLE    = 640,
    parameter int unsigned H_FRONT      = 16,
    parameter int unsigned H_SYNC       = 96,
    parameter int unsigned H_BACK       = 48,
    parameter int unsigned V_VISIBLE    = 480,
    parameter int unsigned V_FRONT      = 10,
    parameter int unsigned V_SYNC       = 2,
    parameter int unsigned V_BACK       = 33,
    parameter int unsigned FB_WIDTH     = 160,
    parameter int unsigned FB_HEIGHT    = 120,
    parameter logic [2:0]  CLEAR_COLOUR = 3'b000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] colour,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic       plot,
    output logic       busy,
    output logic       vga_clk,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b
);

    localparam int unsigned FB_DEPTH = FB_WIDTH * FB_HEIGHT;
    localparam int unsigned AW       = $clog2(FB_DEPTH);

    localparam logic [9:0]  H_LAST     = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0]  H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0]  V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0]  HS_START   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0]  HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0]  VS_START   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0]  VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [14:0] FB_W       = 15'(FB_WIDTH);
    localparam logic [14:0] CLEAR_LAST = 15'(FB_DEPTH - 1);
    localparam logic [7:0]  X_LIMIT    = 8'(FB_WIDTH);
    localparam logic [6:0]  Y_LIMIT    = 7'(FB_HEIGHT);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [14:0] clear_addr_q, clear_addr_d;

    logic        pix_tick_q;
    logic [9:0]  h_q, h_d, v_q, v_d;
    logic        visible, hs_n, vs_n;
    logic [14:0] rd_addr;

    logic        plot_ok, wr_en;
    logic [14:0] plot_addr, wr_addr;
    logic [2:0]  wr_data;

    logic [2:0]  mem [FB_DEPTH];
    logic [2:0]  rd_data_q;
    logic        hs1_q, vs1_q, blank1_q;
    logic        hs2_q, vs2_q, blank2_q;
    logic [7:0]  r_q, g_q, b_q;

    assign busy = (state_q == ST_CLEAR);

    // Clear FSM: one address per clock, then RUN until the next reset.
    always_comb begin
        state_d      = state_q;
        clear_addr_d = clear_addr_q;
        if (state_q == ST_CLEAR) begin
            clear_addr_d = clear_addr_q + 15'd1;
            if (clear_addr_q == CLEAR_LAST) begin
                state_d = ST_RUN;
            end
        end
    end

    // Single write port; the clear owns it while busy so plots are simply dropped.
    assign plot_addr = 15'(y) * FB_W + 15'(x);

    always_comb begin
        plot_ok = plot && !busy && (x < X_LIMIT) && (y < Y_LIMIT);
        wr_en   = busy || plot_ok;
        wr_addr = busy ? clear_addr_q : plot_addr;
        wr_data = busy ? CLEAR_COLOUR : colour;
    end

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (pix_tick_q) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    always_comb begin
        visible = (h_q < H_VIS) && (v_q < V_VIS);
        hs_n    = !((h_q >= HS_START) && (h_q < HS_END));
        vs_n    = !((v_q >= VS_START) && (v_q < VS_END));
    end

    assign rd_addr = 15'(v_q[9:2]) * FB_W + 15'(h_q[9:2]);

    // Registered read sees the pre-write contents on an address collision.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr[AW-1:0]] <= wr_data;
        end
        if (visible) begin
            rd_data_q <= mem[rd_addr[AW-1:0]];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_CLEAR;
            clear_addr_q <= '0;
            pix_tick_q   <= 1'b0;
            h_q          <= '0;
            v_q          <= '0;
            hs1_q        <= 1'b1;
            vs1_q        <= 1'b1;
            blank1_q     <= 1'b0;
            hs2_q        <= 1'b1;
            vs2_q        <= 1'b1;
            blank2_q     <= 1'b0;
            r_q          <= '0;
            g_q          <= '0;
            b_q          <= '0;
        end else begin
            state_q      <= state_d;
            clear_addr_q <= clear_addr_d;
            pix_tick_q   <= ~pix_tick_q;
            h_q          <= h_d;
            v_q          <= v_d;
            // Stage 1 lines sync/blank up with the RAM read; stage 2 drives the pins.
            hs1_q        <= hs_n;
            vs1_q        <= vs_n;
            blank1_q     <= visible;
            hs2_q        <= hs1_q;
            vs2_q        <= vs1_q;
            blank2_q     <= blank1_q;
            r_q          <= blank1_q ? {8{rd_data_q[2]}} : 8'h00;
            g_q          <= blank1_q ? {8{rd_data_q[1]}} : 8'h00;
            b_q          <= blank1_q ? {8{rd_data_q[0]}} : 8'h00;
        end
    end

    // pix_tick rises one clock into each two-clock pixel, so the DAC samples mid-pixel.
    assign vga_clk     = pix_tick_q;
    assign vga_hs      = hs2_q;
    assign vga_vs      = vs2_q;
    assign vga_blank_n = blank2_q;
    assign vga_r       = r_q;
    assign vga_g       = g_q;
    assign vga_b       = b_q;

endmodule
